// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types and constants for the ALU issue arbiter
// Purpose: response FSM state encoding, idle ALU opcode, requester count.
// Ports: none (package).
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    // XOR of two zero operands: the ALU produces 0 when nothing is issued.
    localparam logic [2:0] FUNCT3_NOP = 3'b100;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant logic, purely combinational
// Purpose: picks one of two valid requesters, favouring the one not served last.
// Ports:
//   valid   in  NUM_REQ  request present per port
//   last    in  1        port granted most recently (state held by parent)
//   en      in  1        issue slot open
//   grant   out NUM_REQ  one-hot grant
//   gnt_idx out 1        index of granted port (0 when no grant)
module rr_arb2
    import alu_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic               gnt_idx
);

    // Port 0 wins a tie only when port 1 was served last, and vice versa.
    assign grant[0] = en && valid[0] && (!valid[1] || last);
    assign grant[1] = en && valid[1] && (!valid[0] || !last);
    assign gnt_idx  = grant[1];

endmodule

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - shares one single-cycle registered ALU between two requesters
// Purpose: round-robin issue to the ALU, tracks the one-cycle latency and returns
//          each result with requester id and tag; one-entry hold under back-pressure.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   reqN_valid/ready                request handshake, N = 0 (issue stage), 1 (branch helper)
//   reqN_funct3/funct7/a/b/tag      request fields
//   alu_funct3/funct7/opa/opb       drive to ALU
//   alu_res                         ALU registered result (valid the cycle after issue)
//   rsp_valid/ready                 response handshake
//   rsp_id/tag/data                 response payload
module alu_issue_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_funct3,
    input  logic                  req0_funct7,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [TAG_WIDTH-1:0]  req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_funct3,
    input  logic                  req1_funct7,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [TAG_WIDTH-1:0]  req1_tag,
    output logic [2:0]            alu_funct3,
    output logic                  alu_funct7,
    output logic [DATA_WIDTH-1:0] alu_opa,
    output logic [DATA_WIDTH-1:0] alu_opb,
    input  logic [DATA_WIDTH-1:0] alu_res,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [DATA_WIDTH-1:0] rsp_data
);

    state_e                  r_state;
    logic                    r_last;
    logic                    r_id;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic [DATA_WIDTH-1:0]   r_hold;

    logic                    w_issue_ok;
    logic [NUM_REQ-1:0]      w_grant;
    logic                    w_gnt_idx;
    logic                    w_any_grant;
    logic [TAG_WIDTH-1:0]    w_gnt_tag;

    // A new op may enter only if the response slot frees this cycle. Gating
    // with rstn keeps both ready outputs low while reset is asserted.
    assign w_issue_ok = rstn && ((r_state == IDLE) || rsp_ready);

    rr_arb2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .last    (r_last),
        .en      (w_issue_ok),
        .grant   (w_grant),
        .gnt_idx (w_gnt_idx)
    );

    assign w_any_grant = |w_grant;
    assign req0_ready  = w_grant[0];
    assign req1_ready  = w_grant[1];
    assign w_gnt_tag   = w_gnt_idx ? req1_tag : req0_tag;

    always_comb begin
        alu_funct3 = FUNCT3_NOP;
        alu_funct7 = 1'b0;
        alu_opa    = '0;
        alu_opb    = '0;
        if (w_grant[0]) begin
            alu_funct3 = req0_funct3;
            alu_funct7 = req0_funct7;
            alu_opa    = req0_a;
            alu_opb    = req0_b;
        end else if (w_grant[1]) begin
            alu_funct3 = req1_funct3;
            alu_funct7 = req1_funct7;
            alu_opa    = req1_a;
            alu_opb    = req1_b;
        end
    end

    // id/tag may be overwritten on an issue in EXEC/HOLD because the old
    // response completes in that same cycle (issue requires rsp_ready).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_tag   <= '0;
            r_hold  <= '0;
        end else begin
            if (w_any_grant) begin
                r_last <= w_gnt_idx;
                r_id   <= w_gnt_idx;
                r_tag  <= w_gnt_tag;
            end
            case (r_state)
                IDLE: begin
                    if (w_any_grant) r_state <= EXEC;
                end
                EXEC: begin
                    if (rsp_ready) begin
                        r_state <= w_any_grant ? EXEC : IDLE;
                    end else begin
                        // ALU output is only valid this cycle; park it.
                        r_hold  <= alu_res;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) r_state <= w_any_grant ? EXEC : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state != IDLE);
    assign rsp_id    = r_id;
    assign rsp_tag   = r_tag;
    assign rsp_data  = (r_state == EXEC) ? alu_res :
                       (r_state == HOLD) ? r_hold  : '0;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - directed bench with response scoreboard and ALU model
module tb_alu_issue_arbiter;
    localparam int DW = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]    req0_funct3, req1_funct3;
    logic          req0_funct7, req1_funct7;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [TW-1:0] req0_tag, req1_tag;
    logic [2:0]    alu_funct3;
    logic          alu_funct7;
    logic [DW-1:0] alu_opa, alu_opb, alu_res;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [TW-1:0] rsp_tag;
    logic [DW-1:0] rsp_data;

    int errors = 0;
    int checks = 0;
    logic [DW+TW:0] sb[$];
    logic           exp_last;
    logic           exp_g;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct3(req0_funct3),
        .req0_funct7(req0_funct7), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct3(req1_funct3),
        .req1_funct7(req1_funct7), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_res(alu_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data)
    );

    function automatic logic [DW-1:0] alu_f(input logic [2:0] f3, input logic f7,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (f3)
            3'd0:    return f7 ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, $signed(a) < $signed(b)};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return f7 ? DW'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Registered ALU model: one-cycle latency, reset by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) alu_res <= '0;
        else       alu_res <= alu_f(alu_funct3, alu_funct7, alu_opa, alu_opb);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on response handshake, push on request handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("sb_rsp", 64'({rsp_id, rsp_tag, rsp_data}), 64'(sb.pop_front()));
            end
            if (req0_valid && req0_ready)
                sb.push_back({1'b0, req0_tag, alu_f(req0_funct3, req0_funct7, req0_a, req0_b)});
            if (req1_valid && req1_ready)
                sb.push_back({1'b1, req1_tag, alu_f(req1_funct3, req1_funct7, req1_a, req1_b)});
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [2:0] f3, input logic f7,
                            input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
        req0_valid = v; req0_funct3 = f3; req0_funct7 = f7; req0_a = a; req0_b = b; req0_tag = t;
    endtask

    task automatic set_req1(input logic v, input logic [2:0] f3, input logic f7,
                            input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
        req1_valid = v; req1_funct3 = f3; req1_funct7 = f7; req1_a = a; req1_b = b; req1_tag = t;
    endtask

    initial begin
        // Reset with both requesters asserting valid: readies must stay low.
        rstn = 1'b0;
        rsp_ready = 1'b0;
        set_req0(1'b1, 3'd0, 1'b0, 32'd1, 32'd2, 4'd1);
        set_req1(1'b1, 3'd0, 1'b0, 32'd3, 32'd4, 4'd2);
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);

        // Idle drive.
        drive_edge();
        rstn = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("idle_funct3", 64'(alu_funct3), 64'd4);
        chk("idle_funct7", 64'(alu_funct7), 64'd0);
        chk("idle_ops", 64'({alu_opa, alu_opb}), 64'd0);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);

        // Single op: ADD 5+7, tag 3.
        drive_edge();
        set_req0(1'b1, 3'd0, 1'b0, 32'd5, 32'd7, 4'd3);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", 64'({req1_ready, req0_ready}), 64'd1);
        chk("single_opa", 64'(alu_opa), 64'd5);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_rsp", 64'({rsp_valid, rsp_id, rsp_tag, rsp_data}), {27'd0, 1'b1, 1'b0, 4'd3, 32'd12});
        drive_edge();
        @(negedge clk);
        chk("single_idle", 64'(rsp_valid), 64'd0);

        // Contention: port 0 served last, so port 1 wins first, then alternate.
        exp_last = 1'b0;
        drive_edge();
        set_req0(1'b1, 3'd0, 1'b1, 32'd10, 32'd3, 4'd1);
        set_req1(1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd2, 4'd2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_g = ~exp_last;
            chk("cont_grant", 64'({req1_ready, req0_ready}), 64'({exp_g, ~exp_g}));
            if (i > 0) chk("cont_no_bubble", 64'(rsp_valid), 64'd1);
            exp_last = exp_g;
            drive_edge();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("cont_last_rsp", 64'({rsp_valid, rsp_id, rsp_data}), {31'd0, 1'b1, 1'b0, 32'd7});
        drive_edge();
        @(negedge clk);
        chk("cont_drained", 64'(rsp_valid), 64'd0);

        // Back-pressure: req1 OR, then stall 3 cycles with both ports valid.
        drive_edge();
        set_req1(1'b1, 3'd6, 1'b0, 32'hF0, 32'h0F, 4'd5);
        @(negedge clk);
        chk("bp_issue", 64'({req1_ready, req0_ready}), 64'd2);
        drive_edge();
        rsp_ready = 1'b0;
        set_req0(1'b1, 3'd7, 1'b0, 32'hFF, 32'h3C, 4'd6);
        set_req1(1'b1, 3'd4, 1'b0, 32'hAA, 32'h55, 4'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_rsp", 64'({rsp_valid, rsp_id, rsp_tag, rsp_data}), {27'd0, 1'b1, 1'b1, 4'd5, 32'hFF});
            chk("bp_hold_ready", 64'({req1_ready, req0_ready}), 64'd0);
            drive_edge();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 64'({req1_ready, req0_ready}), 64'd1);
        chk("bp_release_data", 64'(rsp_data), 64'hFF);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_grant", 64'({req1_ready, req0_ready}), 64'd2);
        chk("bp_next_rsp", 64'({rsp_id, rsp_tag, rsp_data}), {27'd0, 1'b0, 4'd6, 32'h3C});
        drive_edge();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_last_rsp", 64'({rsp_id, rsp_tag, rsp_data}), {27'd0, 1'b1, 4'd7, 32'hFF});
        drive_edge();

        // Arithmetic shift right.
        set_req0(1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 4'd9);
        @(negedge clk);
        chk("sra_ready", 64'(req0_ready), 64'd1);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("sra_rsp", 64'({rsp_valid, rsp_tag, rsp_data}), {27'd0, 1'b1, 4'd9, 32'hF800_0000});
        drive_edge();

        // Reset in EXEC with rsp_valid high.
        rsp_ready = 1'b0;
        set_req0(1'b1, 3'd0, 1'b0, 32'd1, 32'd1, 4'd2);
        @(negedge clk);
        chk("rstmid_issue", 64'(req0_ready), 64'd1);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_exec", 64'({rsp_valid, rsp_data}), {31'd0, 1'b1, 32'd2});
        #2;
        rstn = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        drive_edge();
        rstn = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_first_grant", 64'({req1_ready, req0_ready}), 64'd1);
        drive_edge();
        @(negedge clk);
        chk("rstmid_second_grant", 64'({req1_ready, req0_ready}), 64'd2);
        drive_edge();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_idle", 64'(rsp_valid), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one registered ALU between two requesters: the integer issue stage (port 0) and the branch/address helper (port 1).
- Arbitrates round-robin and drives the ALU's funct3/funct7/operand inputs.
- Tracks the single-cycle ALU latency and returns each result with requester ID and tag over a valid/ready response channel.
- Buffers one result under back-pressure and sustains one op per cycle when the consumer is ready.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- TAG_WIDTH, 4, opaque requester tag carried to the response.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_funct3 / req1_funct3  in  3  ALU op select.
- req0_funct7 / req1_funct7  in  1  sub/arith-shift flag.
- req0_a / req1_a  in  DATA_WIDTH  operand A.
- req0_b / req1_b  in  DATA_WIDTH  operand B.
- req0_tag / req1_tag  in  TAG_WIDTH  requester tag.
- alu_funct3  out  3  to ALU funct3.
- alu_funct7  out  1  to ALU funct7.
- alu_opa  out  DATA_WIDTH  to ALU operand A.
- alu_opb  out  DATA_WIDTH  to ALU operand B.
- alu_res  in  DATA_WIDTH  from ALU result; the ALU's result register is clocked by clk and reset by rstn.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the op.
- rsp_tag  out  TAG_WIDTH  tag of that op.
- rsp_data  out  DATA_WIDTH  result.

Behaviour:
- ALU latency is exactly 1: inputs driven in cycle N are valid on alu_res in cycle N+1.
- Issue slot open (issue_ok):
  - state==IDLE, or
  - state in {EXEC, HOLD} and rsp_ready==1.
- Grant:
  - Only when issue_ok and at least one reqX_valid.
  - reqX_ready=1 only for the granted port; at most one ready per cycle.
  - Ready may depend combinationally on valid.
- Round-robin:
  - last_q holds the last granted port.
  - If both ports are valid, grant !last_q; if one is valid, grant it.
  - last_q updates only on a grant.
  - Reset value of last_q is 1, so port 0 wins the first contention.
- On grant:
  - alu_* outputs = granted request fields (combinational mux).
  - id_q/tag_q capture the granted port and its tag.
- No grant:
  - alu_funct3 = 3'b100 (NOP, ALU yields 0), alu_funct7 = 0, operands = 0.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: rsp_valid=0. Grant -> EXEC; else stay.
  - EXEC: rsp_valid=1, rsp_data=alu_res, rsp_id=id_q, rsp_tag=tag_q.
    - rsp_ready=1 and grant -> EXEC (back-to-back).
    - rsp_ready=1, no grant -> IDLE.
    - rsp_ready=0 -> capture alu_res into hold_q; no grant -> HOLD.
  - HOLD: rsp_valid=1, rsp_data=hold_q, id/tag unchanged.
    - rsp_ready=1 and grant -> EXEC.
    - rsp_ready=1, no grant -> IDLE.
    - rsp_ready=0 -> stay.
- In EXEC/HOLD, rsp_id/tag must reflect the op being responded to. When issuing in the same cycle as a handshake, id_q/tag_q are overwritten at the edge; this is correct because the old response completes in that cycle.
- Response outputs stable while rsp_valid && !rsp_ready.
- Requesters hold fields stable while valid && !ready; the arbiter does not re-check.
- Simultaneous req0/req1 with rsp_ready=0 in EXEC/HOLD: no grant, both ready=0, last_q unchanged.
- Reset values (async, any time incl. mid-op):
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_data=0, hold_q=0, last_q=1, req*_ready=0.
  - In-flight op discarded.
- Throughput: 1 op/cycle with rsp_ready held high; no bubbles.
- funct3 values are passed through unmodified; legality is the requester's responsibility.

Decomposition:
- Package alu_ctrl_pkg:
  - state enum {IDLE, EXEC, HOLD}.
  - localparam FUNCT3_NOP = 3'b100.
  - localparam NUM_REQ = 2.
- Sub-module rr_arb2: inputs valid[1:0], last, en; outputs one-hot grant[1:0] and gnt_idx. Purely combinational; last_q lives in the parent.

Test Plan:
- Single op: req0 ADD a=5, b=7, tag=3, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, data=12, id=0, tag=3; then IDLE.
- Contention: both valid every cycle (req0 SUB 10-3 with funct7=1, req1 SLT -1<2), rsp_ready=1 -> grants 0,1,0,1…; responses 7, 1 alternating with matching id/tag; no bubbles.
- Back-pressure: issue req1 OR 0xF0|0x0F, hold rsp_ready=0 for 3 cycles -> HOLD, rsp_data=0xFF stable, ready=0 on both ports; rsp_ready=1 with req0 valid -> same-cycle grant, next rsp is req0's result.
- Shift: req0 SRA a=0x80000000, b=4, funct7=1 -> rsp_data=0xF8000000.
- Reset mid-op: assert rstn=0 in EXEC with rsp_valid=1 -> rsp_valid=0 immediately; after release, both valid -> port 0 granted first.
- Idle drive: no requests -> alu_funct3=3'b100, operands 0, rsp_valid stays 0.
